// File: rtl/sc_level_control.sv
// Game level controller: debounced-by-edge level advance, saturation at MAX_LEVEL,
// and a speed-tick generator whose period shrinks with each level down to a floor.
module sc_level_control #(
  parameter int          LEVEL_WIDTH = 3,
  parameter int          MAX_LEVEL   = 4,
  parameter int unsigned BASE_PERIOD = 32'd25000000,
  parameter int unsigned PERIOD_STEP = 32'd5000000,
  parameter int unsigned MIN_PERIOD  = 32'd2500000
) (
  input  logic                   SC_LEVEL_CONTROL_CLOCK_50,
  input  logic                   SC_LEVEL_CONTROL_RESET_InLow,
  input  logic                   SC_LEVEL_CONTROL_clear_InLow,
  input  logic                   SC_LEVEL_CONTROL_upcount_InLow,
  input  logic                   SC_LEVEL_CONTROL_run_InLow,
  output logic [LEVEL_WIDTH-1:0] SC_LEVEL_CONTROL_level_Out,
  output logic                   SC_LEVEL_CONTROL_COMPARATOR_LEVELS_Out,
  output logic                   SC_LEVEL_CONTROL_newlevel_Out,
  output logic                   SC_LEVEL_CONTROL_tick_Out
);

  localparam logic [LEVEL_WIDTH-1:0] MAX_LVL = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0] ONE_LVL = LEVEL_WIDTH'(1'b1);

  logic [LEVEL_WIDTH-1:0] level_r, level_nx_s;
  logic [31:0]            cnt_r, cnt_nx_s;
  logic [31:0]            dec_s, period_s;
  logic                   max_r, newlevel_r, newlevel_nx_s, tick_r, tick_nx_s;
  logic                   upcount_prev_r, armed_r, advance_s;

  // armed_r masks the first cycle after reset so a request held through reset is ignored
  assign advance_s = armed_r & upcount_prev_r & ~SC_LEVEL_CONTROL_upcount_InLow;

  // Period for the current level, floored; compare before subtracting to avoid underflow
  always_comb begin
    dec_s = 32'(level_r) * PERIOD_STEP;
    if (dec_s >= BASE_PERIOD) begin
      period_s = MIN_PERIOD;
    end else if ((BASE_PERIOD - dec_s) < MIN_PERIOD) begin
      period_s = MIN_PERIOD;
    end else begin
      period_s = BASE_PERIOD - dec_s;
    end
  end

  // Next-state: clear beats advance; any level change restarts the tick counter
  always_comb begin
    level_nx_s    = level_r;
    cnt_nx_s      = cnt_r;
    newlevel_nx_s = 1'b0;
    tick_nx_s     = 1'b0;
    if (!SC_LEVEL_CONTROL_clear_InLow) begin
      level_nx_s = '0;
      cnt_nx_s   = 32'd0;
    end else if (advance_s && (level_r < MAX_LVL)) begin
      level_nx_s    = level_r + ONE_LVL;
      cnt_nx_s      = 32'd0;
      newlevel_nx_s = 1'b1;
    end else if (!SC_LEVEL_CONTROL_run_InLow) begin
      if (cnt_r == (period_s - 32'd1)) begin
        cnt_nx_s  = 32'd0;
        tick_nx_s = 1'b1;
      end else begin
        cnt_nx_s = cnt_r + 32'd1;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // State registers; the upcount sampler keeps running during clear
  always_ff @(posedge SC_LEVEL_CONTROL_CLOCK_50 or negedge SC_LEVEL_CONTROL_RESET_InLow) begin
    if (!SC_LEVEL_CONTROL_RESET_InLow) begin
      level_r        <= '0;
      cnt_r          <= 32'd0;
      max_r          <= 1'b0;
      newlevel_r     <= 1'b0;
      tick_r         <= 1'b0;
      upcount_prev_r <= 1'b1;
      armed_r        <= 1'b0;
    end else begin
      level_r        <= level_nx_s;
      cnt_r          <= cnt_nx_s;
      max_r          <= (level_nx_s == MAX_LVL);
      newlevel_r     <= newlevel_nx_s;
      tick_r         <= tick_nx_s;
      upcount_prev_r <= SC_LEVEL_CONTROL_upcount_InLow;
      armed_r        <= 1'b1;
    end
  end

  assign SC_LEVEL_CONTROL_level_Out             = level_r;
  assign SC_LEVEL_CONTROL_COMPARATOR_LEVELS_Out = max_r;
  assign SC_LEVEL_CONTROL_newlevel_Out          = newlevel_r;
  assign SC_LEVEL_CONTROL_tick_Out              = tick_r;

endmodule

// File: tb/tb_sc_level_control.sv
// Randomized + directed bench for sc_level_control against an integer reference model.
module tb_sc_level_control;

  localparam int LW = 3, MAXL = 3, BASE = 10, STEP = 3, MINP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_n = 1'b1, up_n = 1'b1, run_n = 1'b1;
  logic [LW-1:0] level;
  logic          cmp, newlevel, tick;

  int vectors = 0, miscompares = 0;

  int m_lvl = 0, m_cnt = 0;
  bit m_prev = 1'b1, m_armed = 1'b0, m_nl = 1'b0, m_tk = 1'b0;

  sc_level_control #(
    .LEVEL_WIDTH(LW), .MAX_LEVEL(MAXL), .BASE_PERIOD(BASE),
    .PERIOD_STEP(STEP), .MIN_PERIOD(MINP)
  ) dut (
    .SC_LEVEL_CONTROL_CLOCK_50             (clk),
    .SC_LEVEL_CONTROL_RESET_InLow          (rst_n),
    .SC_LEVEL_CONTROL_clear_InLow          (clear_n),
    .SC_LEVEL_CONTROL_upcount_InLow        (up_n),
    .SC_LEVEL_CONTROL_run_InLow            (run_n),
    .SC_LEVEL_CONTROL_level_Out            (level),
    .SC_LEVEL_CONTROL_COMPARATOR_LEVELS_Out(cmp),
    .SC_LEVEL_CONTROL_newlevel_Out         (newlevel),
    .SC_LEVEL_CONTROL_tick_Out             (tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Period as plain signed arithmetic with a floor.
  function automatic int period_of(input int l);
    int p;
    p = BASE - l * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_cnt = 0; m_prev = 1'b1; m_armed = 1'b0; m_nl = 1'b0; m_tk = 1'b0;
  endtask

  task automatic model_edge();
    bit adv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv = m_armed && m_prev && !up_n;
    m_nl = 1'b0;
    m_tk = 1'b0;
    if (!clear_n) begin
      m_lvl = 0; m_cnt = 0;
    end else if (adv && m_lvl < MAXL) begin
      m_lvl++; m_cnt = 0; m_nl = 1'b1;
    end else if (!run_n) begin
      if (m_cnt == period_of(m_lvl) - 1) begin
        m_cnt = 0; m_tk = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    m_prev  = up_n;
    m_armed = 1'b1;
  endtask

  task automatic compare_all();
    check_val("level", 32'(level), 32'(m_lvl));
    check_val("cmp", 32'(cmp), 32'(m_lvl == MAXL));
    check_val("newlevel", 32'(newlevel), 32'(m_nl));
    check_val("tick", 32'(tick), 32'(m_tk));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must drop before any clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_cmp", 32'(cmp), 32'd0);
    check_val("rst_newlevel", 32'(newlevel), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    model_reset();
    cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse_up();
    up_n = 1'b0; cycle();
    up_n = 1'b1; cycle();
  endtask

  initial begin
    int first_tick;
    #1;
    check_val("init_level", 32'(level), 32'd0);
    check_val("init_tick", 32'(tick), 32'd0);
    @(negedge clk);
    cycles(2);
    rst_n = 1'b1;

    // Level 0 free run: first tick lands on the 10th edge.
    run_n = 1'b0;
    first_tick = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (tick && first_tick == 0) first_tick = i;
    end
    check_val("first_tick_edge", 32'(first_tick), 32'd10);

    // Held-low request advances once.
    up_n = 1'b0; cycles(5);
    up_n = 1'b1; cycles(20);
    check_val("held_adv_level", 32'(level), 32'd1);

    // Three more pulses: 2, 3, saturate at 3.
    for (int i = 0; i < 3; i++) begin
      pulse_up();
      cycles(9);
    end
    check_val("sat_level", 32'(level), 32'd3);
    check_val("sat_cmp", 32'(cmp), 32'd1);

    // Back to level 2, then clear and advance together.
    clear_n = 1'b0; cycle(); clear_n = 1'b1; cycle();
    pulse_up(); pulse_up();
    check_val("lvl2_before_clear", 32'(level), 32'd2);
    clear_n = 1'b0; up_n = 1'b0; cycle();
    clear_n = 1'b1; cycles(3);
    up_n = 1'b1; cycles(3);
    check_val("clear_wins", 32'(level), 32'd0);

    // Pause mid-period.
    cycles(5);
    run_n = 1'b1; cycles(3);
    run_n = 1'b0; cycles(15);

    // Async reset mid-period at level 2, with a request held through reset.
    pulse_up(); pulse_up(); cycles(2);
    up_n = 1'b0;
    async_reset();
    cycles(3);
    up_n = 1'b1;
    cycles(12);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      clear_n = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) up_n = ~up_n;
      run_n = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
